// File: rtl/mult_add_seq_board.sv
// rtl/mult_add_seq_board.sv - sequential shift-add multiplier with accumulate, y = a*b + c
// Optional MULT_OVF_CHECK_EN adds port ovf: result does not fit in WIDTH bits.
module mult_add_seq_board #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] y
`ifdef MULT_OVF_CHECK_EN
    ,
    output logic               ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   y_q, y_d;
    logic                 ovf_q, ovf_d;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 accept;

    // start is honoured from IDLE and DONE, never mid-calculation
    assign accept  = start && (state_q != CALC);
    assign acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);

    always_comb begin
        state_d = state_q;
        mplr_d  = mplr_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = done_q;
        y_d     = y_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    mplr_d  = a;
                    mcand_d = {{WIDTH{1'b0}}, b};
                    acc_d   = {{WIDTH{1'b0}}, c};
                    count_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_sum;
                mplr_d  = mplr_q >> 1;
                mcand_d = mcand_q << 1;
                count_d = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    y_d     = acc_sum;
                    ovf_d   = |acc_sum[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mplr_q  <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;

`ifdef MULT_OVF_CHECK_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: doc/mult_add_seq_board.md
Name: mult_add_seq_board

Overview:
- Sequential 16-bit shift-add multiplier with accumulate. Computes y = a*b + c.
- Inverse of the sequential divider: feeding it quotient, divisor and remainder rebuilds the dividend.
- Uses the divider's start/done handshake and shares the board wrapper and LED display path with it.
- Used on-board and in benches as a round-trip checker for division results.

Parameters:
- WIDTH, 16, operand width in bits; result width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled on rising clk
- a  input  WIDTH  multiplier (divider quotient)
- b  input  WIDTH  multiplicand (divider divisor)
- c  input  WIDTH  addend (divider remainder), zero-extended
- busy  output  1  high while an operation is in progress
- done  output  1  result valid; held high until next accepted start or rst
- y  output  2*WIDTH  registered result a*b + c

Behaviour:
- Reset: clk is the only clock. rst is synchronous and active-high, and has priority over everything.
  - On rst: state=IDLE, busy=0, done=0, y=0, internal acc/count/operand registers=0.
- States: IDLE, CALC, DONE.
- IDLE, start=1:
  - Latch mplr<=a, mcand<=b zero-extended to 2*WIDTH, acc<=c zero-extended, count<=0.
  - Set busy<=1 and go to CALC.
  - start=0: stay in IDLE.
- CALC, one iteration per cycle:
  - If mplr[0], acc<=acc+mcand.
  - Then mplr<=mplr>>1, mcand<=mcand<<1, count<=count+1.
  - On the iteration with count==WIDTH-1: y<=final acc (including that iteration's add), done<=1, busy<=0, go to DONE.
- Latency: start captured at edge N; done and y valid after edge N+WIDTH (16 cycles for default). Fixed latency, no early termination.
- DONE:
  - Hold y and done.
  - start=1 is accepted exactly as in IDLE, and done<=0 on the same edge.
- start while in CALC is ignored. Latched operands are unaffected by input changes after capture.
- y keeps the previous result during a new operation and updates only on completion.
- Width: the 2*WIDTH accumulator cannot overflow. The maximum is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, which is 0xFFFF0000 for W=16.
- Zero operands (a=0 or b=0) still take the full WIDTH cycles; y=c.
- rst mid-CALC aborts the operation. Outputs return to reset values on that edge, and the next start proceeds normally.
- rst and start on the same edge: rst wins and start is dropped.

Optional Feature:
- Macro: MULT_OVF_CHECK_EN
- Defined:
  - Adds output port ovf (1 bit), registered alongside y.
  - ovf<=1 when the final result exceeds 2^WIDTH-1, i.e. the rebuilt dividend does not fit in WIDTH bits.
  - ovf clears on rst and on an accepted start; it is otherwise held with done.
- Not defined: port ovf is absent. All other behaviour is identical.

Test Plan:
- rst pulse; a=4, b=25, c=10, start one cycle -> done rises exactly 16 cycles after start is sampled; y=110; busy high during those 16 cycles.
- Complete one run, then a=870, b=37, c=10, start -> y=32200. Then a=22, b=56, c=2, start from DONE -> done drops on the accepting edge, then y=1234.
- a=16'hFFFF, b=16'hFFFF, c=16'hFFFF -> y=32'hFFFF0000. With MULT_OVF_CHECK_EN: ovf=1. a=0, b=1234, c=7 -> y=7, ovf=0.
- Start a=100, b=3, c=0; pulse start again with a=5 at cycle 5 -> second start ignored, y=300 at the original 16-cycle point.
- Start a=9, b=9, c=0; assert rst at cycle 8 -> busy=0, done=0, y=0 after that edge. New start a=9, b=9 -> y=81 after 16 cycles.
- With MULT_OVF_CHECK_EN: a=1000, b=100, c=0 -> y=100000, ovf=1. Then a=1000, b=65, c=35 -> y=65035, ovf=0.
